// File: rtl/fios_expo_sequencer_if.sv
// -----------------------------------------------------------------------------
// fios_expo_sequencer_if
// Control bundle between the exponentiation sequencer and one FIOS Montgomery
// multiplier (plus the result write port of the operand register file).
// Signal names are written from the sequencer's point of view.
//   mult_start_o : one-cycle start pulse to the multiplier
//   mult_done_i  : multiplier completion pulse
//   sel_a_o      : A-operand source (0 = ACC, 2 = MSG)
//   sel_b_o      : B-operand source (0 = ACC, 1 = R2, 2 = BASE, 3 = ONE)
//   dst_o        : result destination (0 = ACC, 1 = BASE)
//   res_wr_en_o  : result write strobe (done gated by a WAIT state)
// Modports: master = sequencer, slave = multiplier / register-file side.
// -----------------------------------------------------------------------------
interface fios_expo_sequencer_if;
  logic       mult_start_o;
  logic       mult_done_i;
  logic [1:0] sel_a_o;
  logic [1:0] sel_b_o;
  logic       dst_o;
  logic       res_wr_en_o;

  modport master (
    output mult_start_o, sel_a_o, sel_b_o, dst_o, res_wr_en_o,
    input  mult_done_i
  );

  modport slave (
    input  mult_start_o, sel_a_o, sel_b_o, dst_o, res_wr_en_o,
    output mult_done_i
  );
endinterface

// File: rtl/fios_expo_sequencer.sv
// -----------------------------------------------------------------------------
// fios_expo_sequencer
// Left-to-right square-and-multiply scheduler for modular exponentiation.
// Converts the message into the Montgomery domain (MSG x R2 -> BASE), loads
// ACC with Montgomery 1, squares ACC once per exponent bit and multiplies by
// BASE for every set bit, then converts back (ACC x ONE -> ACC).
// No operand data is held here; only state, selects and exponent bookkeeping.
//
// Ports:
//   clock_i, reset_n_i : clock, synchronous active-low reset
//   start_i, exp_i     : run request (sampled in IDLE) and exponent
//   mult_if (master)   : multiplier handshake, operand selects, write strobe
//   acc_init_o         : pulse loading ACC with R mod N
//   busy_o, done_o     : run in progress / one-cycle completion pulse
//
// Optional feature: define FIOS_EXPO_LZ_SKIP_EN to skip the leading zero bits
// of the exponent (SCAN state) instead of squaring Montgomery 1 repeatedly.
// -----------------------------------------------------------------------------
module fios_expo_sequencer #(
  parameter int ELEN = 16
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  input  logic [ELEN-1:0]              exp_i,
  fios_expo_sequencer_if.master        mult_if,
  output logic                         acc_init_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int BW = $clog2(ELEN + 1);

  localparam logic [1:0] SEL_A_ACC  = 2'd0;
  localparam logic [1:0] SEL_A_MSG  = 2'd2;
  localparam logic [1:0] SEL_B_ACC  = 2'd0;
  localparam logic [1:0] SEL_B_R2   = 2'd1;
  localparam logic [1:0] SEL_B_BASE = 2'd2;
  localparam logic [1:0] SEL_B_ONE  = 2'd3;
  localparam logic       DST_ACC    = 1'b0;
  localparam logic       DST_BASE   = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE, S_CONV, S_CONV_W, S_INIT, S_SQ, S_SQ_W, S_MUL, S_MUL_W,
    S_NEXT, S_EXIT, S_EXIT_W, S_DONE
`ifdef FIOS_EXPO_LZ_SKIP_EN
    , S_SCAN
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [ELEN-1:0] exp_q, exp_d;
  logic [BW-1:0]   bit_q, bit_d;

  logic            mult_start_q;
  logic [1:0]      sel_a_q, sel_b_q;
  logic            dst_q;
  logic            wait_q;
  logic            acc_init_q, busy_q, done_q;

  // Current exponent bit; a shift keeps the index width independent of BW.
  logic [ELEN-1:0] exp_shr;
  logic            cur_bit;
  assign exp_shr = exp_q >> bit_q;
  assign cur_bit = exp_shr[0];

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          exp_d   = exp_i;
          bit_d   = BW'(ELEN - 1);
          state_d = S_CONV;
        end
      end
      S_CONV:   state_d = S_CONV_W;
      S_CONV_W: if (mult_if.mult_done_i) state_d = S_INIT;
`ifdef FIOS_EXPO_LZ_SKIP_EN
      S_INIT:   state_d = S_SCAN;
      S_SCAN: begin
        if (cur_bit) begin
          state_d = S_SQ;
        end else if (bit_q != '0) begin
          bit_d = bit_q - BW'(1);
        end else begin
          state_d = S_EXIT;  // exponent is zero: result is Montgomery 1
        end
      end
`else
      S_INIT:   state_d = S_SQ;
`endif
      S_SQ:     state_d = S_SQ_W;
      S_SQ_W:   if (mult_if.mult_done_i) state_d = cur_bit ? S_MUL : S_NEXT;
      S_MUL:    state_d = S_MUL_W;
      S_MUL_W:  if (mult_if.mult_done_i) state_d = S_NEXT;
      S_NEXT: begin
        if (bit_q == '0) begin
          state_d = S_EXIT;
        end else begin
          bit_d   = bit_q - BW'(1);
          state_d = S_SQ;
        end
      end
      S_EXIT:   state_d = S_EXIT_W;
      S_EXIT_W: if (mult_if.mult_done_i) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and all Moore outputs are registered together; outputs are decoded
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      exp_q        <= '0;
      bit_q        <= '0;
      mult_start_q <= 1'b0;
      sel_a_q      <= SEL_A_ACC;
      sel_b_q      <= SEL_B_ACC;
      dst_q        <= DST_ACC;
      wait_q       <= 1'b0;
      acc_init_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      bit_q        <= bit_d;
      mult_start_q <= state_d inside {S_CONV, S_SQ, S_MUL, S_EXIT};
      wait_q       <= state_d inside {S_CONV_W, S_SQ_W, S_MUL_W, S_EXIT_W};
      acc_init_q   <= (state_d == S_INIT);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      sel_a_q      <= SEL_A_ACC;
      sel_b_q      <= SEL_B_ACC;
      dst_q        <= DST_ACC;
      // Selects are held from the issue state through its WAIT state.
      case (state_d)
        S_CONV, S_CONV_W: begin
          sel_a_q <= SEL_A_MSG;
          sel_b_q <= SEL_B_R2;
          dst_q   <= DST_BASE;
        end
        S_MUL, S_MUL_W:   sel_b_q <= SEL_B_BASE;
        S_EXIT, S_EXIT_W: sel_b_q <= SEL_B_ONE;
        default: ;
      endcase
    end
  end

  assign mult_if.mult_start_o = mult_start_q;
  assign mult_if.sel_a_o      = sel_a_q;
  assign mult_if.sel_b_o      = sel_b_q;
  assign mult_if.dst_o        = dst_q;
  // Only output with a combinational input path: stray dones are masked.
  assign mult_if.res_wr_en_o  = mult_if.mult_done_i & wait_q;
  assign acc_init_o           = acc_init_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;

endmodule

// File: tb/tb_fios_expo_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fios_expo_sequencer
// Scoreboard bench: each run pushes its hand-written operation sequence
// (C=CONV, I=acc_init, S=SQ, M=MUL, E=EXIT, D=done) into a queue; a monitor
// pops and compares whenever the sequencer issues an operation, pulses
// acc_init_o or done_o. A multiplier model answers every start after a fixed
// or random latency and checks select stability and the write strobe.
// -----------------------------------------------------------------------------
module tb_fios_expo_sequencer;
  localparam int ELEN = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [ELEN-1:0] exp_in;
  logic            acc_init, busy, done;
  logic            model_done = 1'b0;
  logic            stray_done = 1'b0;

  always #5 clk = ~clk;

  fios_expo_sequencer_if mif ();
  assign mif.mult_done_i = model_done | stray_done;

  fios_expo_sequencer #(.ELEN(ELEN)) dut (
    .clock_i    (clk),
    .reset_n_i  (reset_n),
    .start_i    (start),
    .exp_i      (exp_in),
    .mult_if    (mif),
    .acc_init_o (acc_init),
    .busy_o     (busy),
    .done_o     (done)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  byte sb_q[$];
  int  ops_seen  = 0;
  int  lat_fixed = 4;
  bit  lat_rand  = 1'b0;
  bit  stray_issue = 1'b0;
  int  abort_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic sb_pop(input string name, input byte got);
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got unexpected event '%c' required none", name, got);
    end else begin
      chk(name, got, sb_q.pop_front());
    end
  endtask

  function automatic byte op_code(input logic [1:0] a, input logic [1:0] b, input logic d);
    if (a == 2'd2 && b == 2'd1 && d) return "C";
    if (a == 2'd0 && !d) begin
      case (b)
        2'd0: return "S";
        2'd2: return "M";
        2'd3: return "E";
        default: ;
      endcase
    end
    return "?";
  endfunction

  // Monitor: one line per observed transaction.
  always @(negedge clk) begin
    if (mif.mult_start_o) begin
      ops_seen++;
      $display("[TB] t=%0t op %c", $time, op_code(mif.sel_a_o, mif.sel_b_o, mif.dst_o));
      sb_pop("op", op_code(mif.sel_a_o, mif.sel_b_o, mif.dst_o));
    end
    if (acc_init) sb_pop("acc_init", "I");
    if (done) begin
      $display("[TB] t=%0t done", $time);
      sb_pop("done", "D");
    end
  end

  // Multiplier model.
  initial begin
    int         cnt;
    bit         active;
    int         abort_ref;
    logic [4:0] sel_lat;
    active    = 1'b0;
    cnt       = 0;
    abort_ref = 0;
    sel_lat   = '0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (active) begin
        cnt--;
        if (abort_ref == abort_cnt)
          chk("sel_stable", {mif.sel_a_o, mif.sel_b_o, mif.dst_o}, sel_lat);
        if (cnt <= 0) begin
          model_done = 1'b1;
          active     = 1'b0;
          #1;
          chk("res_wr_en", mif.res_wr_en_o, (abort_ref == abort_cnt) ? 1 : 0);
        end
      end else if (mif.mult_start_o) begin
        active    = 1'b1;
        abort_ref = abort_cnt;
        cnt       = lat_rand ? int'($urandom_range(1, 30)) : lat_fixed;
        sel_lat   = {mif.sel_a_o, mif.sel_b_o, mif.dst_o};
        if (stray_issue) begin
          model_done = 1'b1;  // stray done in the issue cycle must be ignored
          #1;
          chk("stray_issue_wr", mif.res_wr_en_o, 0);
        end
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_outs"}, {mif.mult_start_o, mif.sel_a_o, mif.sel_b_o, mif.dst_o,
                         mif.res_wr_en_o, acc_init, busy, done}, 0);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run(input logic [7:0] e, input string seq, input int nops, input int lat,
                     input bit rnd, input bit stray, input bit mid);
    int ops0;
    int k;
    lat_fixed   = lat;
    lat_rand    = rnd;
    stray_issue = stray;
    for (int i = 0; i < seq.len(); i++) sb_q.push_back(seq[i]);
    ops0   = ops_seen;
    exp_in = e;
    start  = 1'b1;
    #1;
    chk("start_no_comb", {mif.mult_start_o, busy}, 0);
    @(negedge clk);
    start  = 1'b0;
    exp_in = 8'h5A;
    chk("busy_after_start", busy, 1);
    if (mid) begin
      repeat (10) @(negedge clk);
      exp_in = 8'h80;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
    end
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", done, 1);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("mult_ops", ops_seen - ops0, nops);
    chk("sb_empty", sb_q.size(), 0);
    sb_q.delete();
    stray_issue = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    exp_in  = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

`ifdef FIOS_EXPO_LZ_SKIP_EN
    run(8'h05, "CISMSSMED", 7, 4, 1'b0, 1'b0, 1'b0);
    run(8'h00, "CIED", 2, 4, 1'b0, 1'b0, 1'b0);
`else
    run(8'h05, "CISSSSSSMSSMED", 12, 4, 1'b0, 1'b0, 1'b0);
    run(8'h00, "CISSSSSSSSED", 10, 4, 1'b0, 1'b0, 1'b0);
`endif
    run(8'hFF, "CISMSMSMSMSMSMSMSMED", 18, 1, 1'b0, 1'b0, 1'b0);

    // Start pulsed mid-run with another exponent, stray dones in issue cycles.
`ifdef FIOS_EXPO_LZ_SKIP_EN
    run(8'h05, "CISMSSMED", 7, 3, 1'b0, 1'b1, 1'b1);
`else
    run(8'h05, "CISSSSSSMSSMED", 12, 3, 1'b0, 1'b1, 1'b1);
`endif

    // Stray done while idle.
    stray_done = 1'b1;
    #1;
    chk("stray_idle_wr", mif.res_wr_en_o, 0);
    @(negedge clk);
    stray_done = 1'b0;
    chk_idle("stray_idle");
    @(negedge clk);
    chk_idle("stray_idle2");

    // Reset during the first SQ_W, followed by a late done.
    lat_fixed = 4;
    lat_rand  = 1'b0;
`ifdef FIOS_EXPO_LZ_SKIP_EN
    // 0x05 scans bits 7..2 before the first SQ.
    for (int i = 0; i < 3; i++) sb_q.push_back(i == 0 ? 8'h43 : (i == 1 ? 8'h49 : 8'h53));
`else
    for (int i = 0; i < 3; i++) sb_q.push_back(i == 0 ? 8'h43 : (i == 1 ? 8'h49 : 8'h53));
`endif
    exp_in = 8'h05;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (mif.mult_start_o) n++;
      if (n == 2) break;
      @(negedge clk);
    end
    chk("reach_sq", n, 2);
    @(negedge clk);
    reset_n = 1'b0;
    abort_cnt++;
    chk("sb_before_reset", sb_q.size(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_idle("mid_reset");
    repeat (8) @(negedge clk);
    chk_idle("after_late_done");
    sb_q.delete();

`ifdef FIOS_EXPO_LZ_SKIP_EN
    run(8'h05, "CISMSSMED", 7, 2, 1'b0, 1'b0, 1'b0);
    run(8'hA3, "CISMSSMSSSSMSMED", 14, 1, 1'b1, 1'b0, 1'b0);
    run(8'h10, "CISMSSSSED", 8, 1, 1'b1, 1'b0, 1'b0);
`else
    run(8'h05, "CISSSSSSMSSMED", 12, 2, 1'b0, 1'b0, 1'b0);
    run(8'hA3, "CISMSSMSSSSMSMED", 14, 1, 1'b1, 1'b0, 1'b0);
    run(8'h10, "CISSSSMSSSSED", 11, 1, 1'b1, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary required summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
